// File: rtl/sha256_pkg.sv
// sha256_pkg -- round constants, IVs, FSM encoding and round helpers.
// Macro SHA256_MIDSTATE_EN adds the IV_READ state encoding.
package sha256_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_READ    = 3'd1,
      ST_COMPUTE = 3'd2,
      ST_WRITE   = 3'd3
`ifdef SHA256_MIDSTATE_EN
      ,
      ST_IV_READ = 3'd4
`endif
   } state_e;

   // Working variables a..h, index 0 is a
   typedef logic [7:0][31:0] work_t;

   localparam logic [31:0] K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [31:0] IV [0:7] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   function automatic logic [31:0] ror(
      input logic [31:0] x,
      input int unsigned n
   );
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] bsig0(input logic [31:0] x);
      return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
   endfunction

   function automatic logic [31:0] bsig1(input logic [31:0] x);
      return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
   endfunction

   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
   endfunction

   function automatic work_t sha_round(
      input work_t       s,
      input logic [31:0] k,
      input logic [31:0] w
   );
      logic [31:0] t1;
      logic [31:0] t2;
      work_t       r;
      t1 = s[7] + bsig1(s[4])
         + ((s[4] & s[5]) ^ (~s[4] & s[6])) + k + w;
      t2 = bsig0(s[0])
         + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
      r[0] = t1 + t2;
      r[1] = s[0];
      r[2] = s[1];
      r[3] = s[2];
      r[4] = s[3] + t1;
      r[5] = s[4];
      r[6] = s[5];
      r[7] = s[6];
      return r;
   endfunction

endpackage

// File: rtl/sha256_wsched.sv
// sha256_wsched -- 16-word shifting message schedule window.
// Loads message words in READ, generates W[t+16] in COMPUTE.
module sha256_wsched
   import sha256_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        expand,
   input  logic [31:0] din,
   output logic [31:0] w_cur
);

   logic [31:0] win [0:15];
   logic [31:0] w_new;

   assign w_new = ssig1(win[14]) + win[9] + ssig0(win[1]) + win[0];
   assign w_cur = win[0];

   // Shift toward index 0; new word enters at 15 (fetched or expanded)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) win[i] <= '0;
      end else if (load || expand) begin
         for (int i = 0; i < 15; i++) win[i] <= win[i+1];
         win[15] <= load ? din : w_new;
      end
   end

endmodule

// File: rtl/sha256_multiblock_hasher.sv
// sha256_multiblock_hasher -- word-oriented multi-block SHA-256 engine.
// Macro SHA256_MIDSTATE_EN: load the chaining IV from iv_addr.
module sha256_multiblock_hasher
   import sha256_pkg::*;
#(
   parameter int MAX_WORDS = 1024,
   parameter int ADDR_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [15:0]       num_words,
   input  logic [ADDR_W-1:0] input_addr,
   input  logic [ADDR_W-1:0] hash_addr,
`ifdef SHA256_MIDSTATE_EN
   input  logic [ADDR_W-1:0] iv_addr,
`endif
   output logic              done,
   output logic              memory_clk,
   output logic              enable_write,
   output logic [ADDR_W-1:0] memory_addr,
   output logic [31:0]       memory_write_data,
   input  logic [31:0]       memory_read_data
);

   state_e            state;
   logic [15:0]       nw_q;
   logic [15:0]       nblk;
   logic [15:0]       blk;
   logic [16:0]       base_w;
   logic [4:0]        rcnt;
   logic [6:0]        rnd;
   logic [3:0]        wcnt;
   logic [ADDR_W-1:0] in_base;
   logic [ADDR_W-1:0] out_base;
   logic [31:0]       hash [0:7];
   logic [31:0]       hash_nxt [0:7];
   work_t             st;

   logic [15:0]       nw_c;
   logic [15:0]       nblk_c;
   logic [16:0]       g;
   logic              last_blk;
   logic [31:0]       len_lo;
   logic [31:0]       fill;
   logic [31:0]       w_cur;
   logic              ws_load;
   logic              ws_expand;

   assign memory_clk = clk;

   assign nw_c   = (num_words > 16'(MAX_WORDS)) ? 16'(MAX_WORDS)
                                                : num_words;
   assign nblk_c = 16'((17'(nw_c) + 17'd18) >> 4);

   assign g        = base_w + 17'(rcnt) - 17'd1;
   assign last_blk = (blk == nblk - 16'd1);
   assign len_lo   = {11'd0, nw_q, 5'd0};

   // Word entering the window: message, pad marker, length or zero
   always_comb begin
      fill = 32'd0;
      if (g < {1'b0, nw_q})
         fill = memory_read_data;
      else if (g == {1'b0, nw_q})
         fill = 32'h8000_0000;
      else if (last_blk && rcnt == 5'd16)
         fill = len_lo;
   end

   // Chaining value plus the finished working variables
   always_comb begin
      for (int i = 0; i < 8; i++) hash_nxt[i] = hash[i] + st[i];
   end

   assign ws_load   = (state == ST_READ) && (rcnt != 5'd0);
   assign ws_expand = (state == ST_COMPUTE) && !rnd[6];

   sha256_wsched u_wsched (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (ws_load),
      .expand (ws_expand),
      .din    (fill),
      .w_cur  (w_cur)
   );

   // Main sequencer: fetch, 64 rounds + fold, digest write-back
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= ST_IDLE;
         done              <= 1'b0;
         enable_write      <= 1'b0;
         memory_addr       <= '0;
         memory_write_data <= '0;
         nw_q              <= '0;
         nblk              <= '0;
         blk               <= '0;
         base_w            <= '0;
         rcnt              <= '0;
         rnd               <= '0;
         wcnt              <= '0;
         in_base           <= '0;
         out_base          <= '0;
         st                <= '0;
         for (int i = 0; i < 8; i++) hash[i] <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (start && !done) begin
                  nw_q     <= nw_c;
                  nblk     <= nblk_c;
                  blk      <= '0;
                  base_w   <= '0;
                  rcnt     <= '0;
                  in_base  <= input_addr;
                  out_base <= hash_addr;
`ifdef SHA256_MIDSTATE_EN
                  state       <= ST_IV_READ;
                  memory_addr <= iv_addr;
`else
                  state       <= ST_READ;
                  memory_addr <= input_addr;
                  for (int i = 0; i < 8; i++) hash[i] <= IV[i];
`endif
               end
            end
`ifdef SHA256_MIDSTATE_EN
            ST_IV_READ: begin
               memory_addr <= memory_addr + ADDR_W'(1);
               if (rcnt != 5'd0)
                  hash[rcnt[2:0] - 3'd1] <= memory_read_data;
               if (rcnt == 5'd8) begin
                  state       <= ST_READ;
                  rcnt        <= '0;
                  memory_addr <= in_base;
               end else begin
                  rcnt <= rcnt + 5'd1;
               end
            end
`endif
            ST_READ: begin
               memory_addr <= memory_addr + ADDR_W'(1);
               if (rcnt == 5'd16) begin
                  state <= ST_COMPUTE;
                  rnd   <= '0;
                  for (int i = 0; i < 8; i++) st[i] <= hash[i];
               end else begin
                  rcnt <= rcnt + 5'd1;
               end
            end
            ST_COMPUTE: begin
               if (!rnd[6]) begin
                  st  <= sha_round(st, K[rnd[5:0]], w_cur);
                  rnd <= rnd + 7'd1;
               end else begin
                  for (int i = 0; i < 8; i++) hash[i] <= hash_nxt[i];
                  if (last_blk) begin
                     state             <= ST_WRITE;
                     enable_write      <= 1'b1;
                     memory_addr       <= out_base;
                     memory_write_data <= hash_nxt[0];
                     wcnt              <= 4'd1;
                  end else begin
                     state       <= ST_READ;
                     blk         <= blk + 16'd1;
                     base_w      <= base_w + 17'd16;
                     rcnt        <= '0;
                     memory_addr <= in_base
                                  + ADDR_W'(base_w + 17'd16);
                  end
               end
            end
            ST_WRITE: begin
               if (wcnt == 4'd8) begin
                  enable_write <= 1'b0;
                  done         <= 1'b1;
                  state        <= ST_IDLE;
               end else begin
                  memory_addr       <= memory_addr + ADDR_W'(1);
                  memory_write_data <= hash[wcnt[2:0]];
                  wcnt              <= wcnt + 4'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/sha256_multiblock_hasher.md
SHA256_MULTIBLOCK_HASHER -- requirements
Module: sha256_multiblock_hasher

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 1024: largest message length in 32-bit words.
REQ-002 SHALL have parameter ADDR_W, default 16: memory word-address width.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: begin a hash when sampled high in IDLE.
REQ-006 SHALL have port num_words, input, 16: message length in words, sampled with start.
REQ-007 SHALL have ports input_addr and hash_addr, input, ADDR_W each: base addresses of the message and of the digest.
REQ-008 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-009 SHALL have port memory_clk, output, 1: equal to clk.
REQ-010 SHALL have port enable_write, output, 1: memory write strobe.
REQ-011 SHALL have ports memory_addr (output, ADDR_W) and memory_write_data (output, 32).
REQ-012 SHALL have port memory_read_data, input, 32: valid on the cycle after its address is presented.

Function
REQ-013 SHALL sequence states IDLE -> READ -> COMPUTE -> (READ | WRITE) -> IDLE.
REQ-014 SHALL ignore start outside IDLE.
REQ-015 SHALL latch num_words at start and clamp it to MAX_WORDS.
REQ-016 SHALL process blocks = ceil((num_words+3)/16), computed at start.
REQ-017 READ SHALL fetch one word per cycle, big-endian, into the 16-word schedule window.
REQ-018 After the message words, READ SHALL insert 32'h80000000, then zero words, then the 64-bit bit length (num_words*32) as words 14 and 15 of the last block.
REQ-019 If the pad word does not fit in the final data block, it SHALL start the final block.
REQ-020 COMPUTE SHALL perform exactly one SHA-256 round per cycle for 64 cycles, with W[t] for t>=16 generated on the fly from the 16-word window.
REQ-021 COMPUTE SHALL spend one further cycle adding A..H into hash0..hash7, mod 2^32.
REQ-022 After the last block, WRITE SHALL assert enable_write for 8 consecutive cycles, writing hash0..hash7 to hash_addr+0..+7.
REQ-023 done SHALL pulse high for exactly one cycle, the cycle after the final write, as the block re-enters IDLE.
REQ-024 Addresses SHALL wrap modulo 2^ADDR_W.
REQ-025 num_words=0 SHALL produce a single padding-only block.
REQ-026 start coincident with done SHALL be ignored; a new start is accepted from the next cycle.

Reset
REQ-027 rst_n low SHALL immediately force state=IDLE and done=0, enable_write=0, memory_addr=0, memory_write_data=0.
REQ-028 A reset mid-operation SHALL abandon the hash with no further memory writes.
REQ-029 After reset the block SHALL accept start on the first edge with rst_n high.

Configuration
REQ-030 With SHA256_MIDSTATE_EN defined, an input iv_addr (ADDR_W) SHALL be present.
REQ-031 With SHA256_MIDSTATE_EN defined, an IV_READ state SHALL precede READ and load hash0..hash7 from iv_addr+0..+7.
REQ-032 With SHA256_MIDSTATE_EN defined, the length field SHALL still encode only num_words*32.
REQ-033 Without SHA256_MIDSTATE_EN, iv_addr and IV_READ SHALL be absent and hash0..hash7 SHALL load the FIPS 180-4 initial values.

Structure
REQ-034 Package sha256_pkg SHALL hold the K[0:63] table, the eight IV constants, the state enum, and the ror/round/sigma functions.
REQ-035 Sub-module sha256_wsched SHALL implement the 16-entry shifting window: load during READ, expand during COMPUTE.

Verification
REQ-036 num_words=0 -> memory at hash_addr = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855, done pulsed once.
REQ-037 num_words=13 and num_words=14 -> 1 and 2 blocks respectively; digests match the reference model.
REQ-038 num_words=40 -> 3 blocks; digest matches the model; exactly 8 write strobes.
REQ-039 rst_n pulsed low during COMPUTE of block 2 -> no writes and no done; a restarted hash then gives the correct digest.
REQ-040 start pulsed while busy, and hash_addr=16'hFFFC -> start ignored; writes wrap to 0000..0003.
REQ-041 With SHA256_MIDSTATE_EN: IV memory = standard IVs -> digest identical to the macro-off build.
